// File: rtl/semaforo.sv
// Two-way traffic-light controller: light A cycles GREEN -> YELLOW -> RED with
// per-colour dwell times, light B shows the complementary colour; bt cuts A's green short.
module semaforo #(
   parameter logic [7:0] VERDE    = 8'd1,
   parameter logic [7:0] AMARELO  = 8'd3,
   parameter logic [7:0] VERMELHO = 8'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bt,
   output logic [2:0] A,
   output logic [2:0] B
);

   typedef enum logic [1:0] {
      PH_G = 2'd0,
      PH_Y = 2'd1,
      PH_R = 2'd2
   } phase_t;

   // A dwell of 0 behaves as a single-cycle phase.
   localparam logic [7:0] DW_G = (VERDE    == 8'd0) ? 8'd1 : VERDE;
   localparam logic [7:0] DW_Y = (AMARELO  == 8'd0) ? 8'd1 : AMARELO;
   localparam logic [7:0] DW_R = (VERMELHO == 8'd0) ? 8'd1 : VERMELHO;

   localparam logic [2:0] C_GREEN  = 3'b001;
   localparam logic [2:0] C_YELLOW = 3'b010;
   localparam logic [2:0] C_RED    = 3'b100;

   phase_t     phase, phase_next;
   logic [7:0] cnt, cnt_next;
   logic [7:0] last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= PH_G;
         cnt   <= 8'd0;
      end else begin
         phase <= phase_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      phase_next = phase;
      cnt_next   = cnt + 8'd1;
      last       = DW_G - 8'd1;
      case (phase)
         PH_G: last = DW_G - 8'd1;
         PH_Y: last = DW_Y - 8'd1;
         PH_R: last = DW_R - 8'd1;
         default: last = 8'd0;
      endcase

      if (phase == PH_G && bt) begin
         phase_next = PH_Y;
         cnt_next   = 8'd0;
      end else if (cnt >= last) begin
         cnt_next = 8'd0;
         case (phase)
            PH_G:    phase_next = PH_Y;
            PH_Y:    phase_next = PH_R;
            PH_R:    phase_next = PH_G;
            default: phase_next = PH_G;
         endcase
      end
   end

   // Lights decode from the phase register only, so bt never reaches them combinationally.
   always_comb begin
      A = C_GREEN;
      B = C_RED;
      case (phase)
         PH_G: begin A = C_GREEN;  B = C_RED;   end
         PH_Y: begin A = C_YELLOW; B = C_RED;   end
         PH_R: begin A = C_RED;    B = C_GREEN; end
         default: begin A = C_GREEN; B = C_RED; end
      endcase
   end

endmodule

// File: tb/tb_semaforo.sv
// Randomised bench for semaforo: four parameterisations run side by side against
// a colour/elapsed-edges model, plus literal checks that pin the model.
`timescale 1ns/1ps
module tb_semaforo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] bt_v = 4'b0;
   logic [2:0] a_o [4];
   logic [2:0] b_o [4];

   int chk_cnt  = 0;
   int pass_cnt = 0;
   bit en       = 1'b0;

   always #1 clk = ~clk;

   semaforo u_def (.clk(clk), .rst(rst), .bt(bt_v[0]), .A(a_o[0]), .B(b_o[0]));
   semaforo #(.VERDE(8'd5)) u_v5 (.clk(clk), .rst(rst), .bt(bt_v[1]), .A(a_o[1]), .B(b_o[1]));
   semaforo #(.VERDE(8'd255), .AMARELO(8'd255), .VERMELHO(8'd255)) u_max
      (.clk(clk), .rst(rst), .bt(bt_v[2]), .A(a_o[2]), .B(b_o[2]));
   semaforo #(.VERMELHO(8'd0)) u_r0 (.clk(clk), .rst(rst), .bt(bt_v[3]), .A(a_o[3]), .B(b_o[3]));

   // Effective dwell per instance and colour (green, yellow, red); a 0 parameter means 1.
   int dw [4][3] = '{'{1, 3, 2}, '{5, 3, 2}, '{255, 255, 255}, '{1, 3, 1}};
   int col [4];   // 0 green, 1 yellow, 2 red
   int el  [4];   // edges already spent in the current colour

   function automatic logic [2:0] colour_a(int c);
      return (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b100;
   endfunction
   function automatic logic [2:0] colour_b(int c);
      return (c == 2) ? 3'b001 : 3'b100;
   endfunction

   always @(posedge clk or negedge rst) begin
      for (int k = 0; k < 4; k++) begin
         if (!rst) begin
            col[k] <= 0;
            el[k]  <= 0;
         end else if (col[k] == 0 && bt_v[k]) begin
            col[k] <= 1;
            el[k]  <= 0;
         end else if (el[k] + 1 >= dw[k][col[k]]) begin
            col[k] <= (col[k] + 1) % 3;
            el[k]  <= 0;
         end else begin
            el[k] <= el[k] + 1;
         end
      end
   end

   task automatic check(input string name, input int inst, input logic [2:0] got, input logic [2:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s inst=%0d got=%b expected=%b t=%0t", name, inst, got, exp, $time);
   endtask

   always @(negedge clk) begin
      if (en) begin
         for (int k = 0; k < 4; k++) begin
            check("model_A", k, a_o[k], colour_a(col[k]));
            check("model_B", k, b_o[k], colour_b(col[k]));
         end
      end
   end

   logic [2:0] seq_def [7] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b010};

   initial begin
      en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_A", 0, a_o[0], 3'b001);
      check("reset_B", 0, b_o[0], 3'b100);
      rst = 1'b1;

      // Free run plus a button press at cnt=1 on the VERDE=5 instance.
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk);
         @(negedge clk);
         $display("edge %0d def A=%b B=%b v5 A=%b r0 A=%b", i, a_o[0], b_o[0], a_o[1], a_o[3]);
         check("seq_def", 0, a_o[0], seq_def[i-1]);
         if (i == 1) bt_v[1] = 1'b1;
         if (i == 2) begin
            bt_v[1] = 1'b0;
            check("bt_cut_green", 1, a_o[1], 3'b010);
         end
         if (i == 4) begin
            check("v5_yellow_full", 1, a_o[1], 3'b010);
            check("r0_red", 3, a_o[3], 3'b100);
         end
         if (i == 5) begin
            check("v5_yellow_end", 1, a_o[1], 3'b100);
            check("r0_red_1edge", 3, a_o[3], 3'b001);
         end
      end

      // Asynchronous reset mid-yellow on the default instance.
      @(posedge clk);
      #0.5 rst = 1'b0;
      #0.1;
      $display("async reset def A=%b B=%b", a_o[0], b_o[0]);
      check("async_A", 0, a_o[0], 3'b001);
      check("async_B", 0, b_o[0], 3'b100);
      @(negedge clk);
      rst = 1'b1;

      // Max-dwell corner: green holds for exactly 255 edges.
      for (int i = 1; i <= 255; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 254) check("max_green_hold", 2, a_o[2], 3'b001);
         if (i == 255) check("max_green_end", 2, a_o[2], 3'b010);
      end

      // Randomised run: pulses, held presses and occasional async resets.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         bt_v[0] = (i % 400 < 60) ? 1'b1 : ($urandom_range(0, 5) == 0);
         bt_v[1] = ($urandom_range(0, 9) == 0);
         bt_v[2] = ($urandom_range(0, 199) == 0);
         bt_v[3] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #0.4 rst = 1'b0;
            #0.3;
            check("rand_async_A", 0, a_o[0], 3'b001);
            @(negedge clk);
            rst = 1'b1;
         end
      end

      @(negedge clk);
      en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
